// File: rtl/net_packet_dispatch_pkg.sv
// Shared network packet definitions for the per-core endpoint and its
// dispatch state machine.
package net_packet_dispatch_pkg;

  localparam int imem_addr_width_gp = 10;
  localparam int rs_imm_size_gp     = 5;
  localparam int mask_length_gp     = 8;
  localparam int id_width_gp        = 6;
  localparam int net_addr_width_gp  = imem_addr_width_gp;
  localparam int net_data_width_gp  = 32;

  typedef enum logic [2:0] {
    NET_NULL  = 3'd0,
    NET_INSTR = 3'd1,
    NET_REG   = 3'd2,
    NET_PC    = 3'd3,
    NET_BAR   = 3'd4
  } net_op_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [15:0] imm;
  } instruction_s;

  typedef struct packed {
    logic [id_width_gp-1:0]       ID;
    net_op_e                      net_op;
    logic [net_addr_width_gp-1:0] net_addr;
    logic [net_data_width_gp-1:0] net_data;
  } net_packet_s;

  // Buffered form of a packet: the ID has already been matched on entry.
  typedef struct packed {
    net_op_e                      net_op;
    logic [net_addr_width_gp-1:0] net_addr;
    logic [net_data_width_gp-1:0] net_data;
  } net_cmd_s;

  typedef enum logic [1:0] {
    HALTED   = 2'd0,
    RUNNING  = 2'd1,
    STOPPING = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/net_packet_dispatch_fifo.sv
// Generic synchronous FIFO with full/empty flags and no write-to-read bypass.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module net_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = $clog2(els_p);

  logic [ptr_w:0]     wr_q, wr_d, rd_q, rd_d;
  logic [width_p-1:0] mem_q [els_p];
  logic               push, pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[ptr_w] != rd_q[ptr_w]) && (wr_q[ptr_w-1:0] == rd_q[ptr_w-1:0]);
  assign push    = v_i & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem_q[rd_q[ptr_w-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[ptr_w-1:0]] <= data_i;
  end

endmodule

// File: rtl/net_packet_dispatch.sv
// Per-core network endpoint: buffers packets addressed to this core, decodes
// the FIFO head into IMEM/register/barrier/PC strobes and owns run/halt.
module net_packet_dispatch
  import net_packet_dispatch_pkg::*;
#(
  parameter int fifo_depth_p    = 4,
  parameter int err_cnt_width_p = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  net_packet_s                   net_packet_i,
  input  logic [id_width_gp-1:0]        my_id_i,
  output logic                          net_ready_o,
  input  logic                          imem_ready_i,
  output logic                          imem_w_v_o,
  output logic [imem_addr_width_gp-1:0] imem_addr_o,
  output instruction_s                  imem_data_o,
  output logic                          reg_w_v_o,
  output logic [rs_imm_size_gp-1:0]     reg_addr_o,
  output logic [31:0]                   reg_data_o,
  output logic                          bar_w_v_o,
  output logic [mask_length_gp-1:0]     bar_mask_o,
  output logic                          pc_w_v_o,
  output logic [imem_addr_width_gp-1:0] pc_o,
  output logic                          run_o,
  output logic [err_cnt_width_p-1:0]    err_cnt_o
);

  dispatch_state_e              state_q;
  logic                         run_q;
  logic [err_cnt_width_p-1:0]   err_q, err_d;
  logic                         fifo_full, fifo_empty;
  logic                         accept, pop, head_v;
  logic                         err_inc, go_run, stop_req;
  logic [$bits(net_cmd_s)-1:0]  head_raw;
  net_cmd_s                     in_cmd, head;

  assign net_ready_o = ~fifo_full & ~reset;
  assign accept      = (net_packet_i.net_op != NET_NULL) && (net_packet_i.ID == my_id_i) && net_ready_o;
  assign in_cmd      = '{net_op: net_packet_i.net_op, net_addr: net_packet_i.net_addr,
                         net_data: net_packet_i.net_data};

  net_fifo #(
    .width_p ($bits(net_cmd_s)),
    .els_p   (fifo_depth_p)
  ) fifo (
    .clk     (clk),
    .reset   (reset),
    .v_i     (accept),
    .data_i  (in_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head_raw),
    .yumi_i  (pop)
  );

  assign head   = net_cmd_s'(head_raw);
  // Reset suppresses dispatch in the cycle it is asserted, not only after.
  assign head_v = ~fifo_empty & ~reset;

  always_comb begin
    imem_w_v_o = 1'b0;
    reg_w_v_o  = 1'b0;
    bar_w_v_o  = 1'b0;
    pc_w_v_o   = 1'b0;
    pop        = 1'b0;
    err_inc    = 1'b0;
    go_run     = 1'b0;
    stop_req   = 1'b0;
    if (head_v) begin
      case (head.net_op)
        NET_INSTR: begin
          if (state_q == HALTED) begin
            imem_w_v_o = imem_ready_i;
            pop        = imem_ready_i;
          end else if (state_q == RUNNING) begin
            stop_req = 1'b1;
          end
        end
        NET_REG: begin
          if (state_q == HALTED) begin
            reg_w_v_o = 1'b1;
            pop       = 1'b1;
          end else if (state_q == RUNNING) begin
            stop_req = 1'b1;
          end
        end
        NET_PC: begin
          if (state_q == HALTED) begin
            pc_w_v_o  = 1'b1;
            bar_w_v_o = 1'b1;
            pop       = 1'b1;
            go_run    = 1'b1;
          end else if (state_q == RUNNING) begin
            stop_req = 1'b1;
          end
        end
        NET_BAR: begin
          if (state_q != STOPPING) begin
            bar_w_v_o = 1'b1;
            pop       = 1'b1;
          end
        end
        default: begin
          // Unknown ops are dropped and counted; STOPPING still blocks them.
          if (state_q != STOPPING) begin
            pop     = 1'b1;
            err_inc = 1'b1;
          end
        end
      endcase
    end
  end

  assign imem_addr_o = head_v ? head.net_addr[imem_addr_width_gp-1:0] : '0;
  assign imem_data_o = head_v ? instruction_s'(head.net_data[$bits(instruction_s)-1:0]) : '0;
  assign reg_addr_o  = head_v ? head.net_addr[rs_imm_size_gp-1:0] : '0;
  assign reg_data_o  = head_v ? head.net_data : '0;
  assign bar_mask_o  = head_v ? head.net_data[mask_length_gp-1:0] : '0;
  assign pc_o        = head_v ? head.net_addr[imem_addr_width_gp-1:0] : '0;

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HALTED;
      run_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      err_q <= err_d;
      case (state_q)
        HALTED: begin
          if (go_run) begin
            state_q <= RUNNING;
            run_q   <= 1'b1;
          end
        end
        RUNNING: begin
          if (stop_req) begin
            state_q <= STOPPING;
            run_q   <= 1'b0;
          end
        end
        STOPPING: begin
          state_q <= HALTED;
          run_q   <= 1'b0;
        end
        default: begin
          state_q <= HALTED;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  assign run_o     = run_q & ~reset;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_net_packet_dispatch.sv
// Scoreboard bench: accepted packets push expected strobe events, a negedge
// monitor pops and compares each strobe the endpoint presents.
module tb_net_packet_dispatch;
  import net_packet_dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int ERRW  = 8;
  localparam int K_INSTR = 1, K_REG = 2, K_PC = 3, K_BAR = 4;

  logic                          clk = 1'b0;
  logic                          reset;
  net_packet_s                   pkt;
  logic [id_width_gp-1:0]        my_id;
  logic                          rdy_cmd, rnd_rdy, rand_en, imem_ready;
  logic                          net_ready_o, imem_w_v_o, reg_w_v_o, bar_w_v_o, pc_w_v_o, run_o;
  logic [imem_addr_width_gp-1:0] imem_addr_o, pc_o;
  instruction_s                  imem_data_o;
  logic [rs_imm_size_gp-1:0]     reg_addr_o;
  logic [31:0]                   reg_data_o;
  logic [mask_length_gp-1:0]     bar_mask_o;
  logic [ERRW-1:0]               err_cnt_o;

  assign imem_ready = rand_en ? rnd_rdy : rdy_cmd;

  net_packet_dispatch #(.fifo_depth_p(DEPTH), .err_cnt_width_p(ERRW)) dut (
    .clk(clk), .reset(reset), .net_packet_i(pkt), .my_id_i(my_id), .net_ready_o(net_ready_o),
    .imem_ready_i(imem_ready), .imem_w_v_o(imem_w_v_o), .imem_addr_o(imem_addr_o),
    .imem_data_o(imem_data_o), .reg_w_v_o(reg_w_v_o), .reg_addr_o(reg_addr_o),
    .reg_data_o(reg_data_o), .bar_w_v_o(bar_w_v_o), .bar_mask_o(bar_mask_o),
    .pc_w_v_o(pc_w_v_o), .pc_o(pc_o), .run_o(run_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int     n_tests = 0, n_fail = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int unsigned addr; int unsigned data; } ev_t;
  ev_t    exp_q[$];
  longint instr_cyc[$];
  int     unk_cnt = 0;

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic net_packet_s mk(logic [id_width_gp-1:0] id, logic [2:0] op,
                                     int unsigned addr, int unsigned data);
    net_packet_s p;
    p.ID       = id;
    p.net_op   = net_op_e'(op);
    p.net_addr = addr[net_addr_width_gp-1:0];
    p.net_data = data;
    return p;
  endfunction

  // Reference: each accepted packet maps to one strobe event in arrival order.
  task automatic model_accept(net_packet_s p);
    ev_t e;
    int unsigned a = 32'(p.net_addr);
    int unsigned d = p.net_data;
    e.addr = 0;
    e.data = 0;
    case (int'(p.net_op))
      1: begin e.kind = K_INSTR; e.addr = a % (1 << imem_addr_width_gp); e.data = d; end
      2: begin e.kind = K_REG;   e.addr = a % (1 << rs_imm_size_gp);     e.data = d; end
      3: begin e.kind = K_PC;    e.addr = a % (1 << imem_addr_width_gp); e.data = d % (1 << mask_length_gp); end
      4: begin e.kind = K_BAR;   e.data = d % (1 << mask_length_gp); end
      default: e.kind = 0;
    endcase
    if (e.kind == 0) unk_cnt++;
    else exp_q.push_back(e);
  endtask

  // Caller must be aligned just after a rising edge.
  task automatic send(net_packet_s p);
    bit own, ok, r;
    own = (p.net_op != NET_NULL) && (p.ID == my_id);
    ok  = 1'b0;
    pkt = p;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      r = net_ready_o;
      @(posedge clk);
      #1;
      if (!own) begin ok = 1'b1; break; end
      if (r) begin model_accept(p); ok = 1'b1; break; end
    end
    pkt = '0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int unsigned ka, kd;
    int          ak, ns;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ns = int'(imem_w_v_o) + int'(reg_w_v_o) + int'(pc_w_v_o) + int'(bar_w_v_o && !pc_w_v_o);
        if (ns > 1) chk("multi_strobe", ns, 1);
        else if (ns == 1) begin
          if (imem_w_v_o)     begin ak = K_INSTR; ka = 32'(imem_addr_o); kd = 32'(imem_data_o); end
          else if (reg_w_v_o) begin ak = K_REG;   ka = 32'(reg_addr_o);  kd = reg_data_o; end
          else if (pc_w_v_o)  begin ak = K_PC;    ka = 32'(pc_o);        kd = 32'(bar_mask_o); end
          else                begin ak = K_BAR;   ka = 0;                kd = 32'(bar_mask_o); end
          if (pc_w_v_o) chk("pc_with_bar", bar_w_v_o, 1);
          if (ak != K_BAR) chk("write_while_run", run_o, 0);
          if (ak == K_INSTR) instr_cyc.push_back(cyc);
          if (exp_q.size() == 0) chk("unexpected_strobe_kind", ak, 0);
          else begin
            e = exp_q.pop_front();
            chk("ev_kind", ak, e.kind);
            chk("ev_addr", ka, e.addr);
            chk("ev_data", kd, e.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pkt = '0; my_id = 6'd9; rdy_cmd = 1'b1; rand_en = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_run", run_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_ready", net_ready_o, 1);
    chk("rst_strobes", {imem_w_v_o, reg_w_v_o, bar_w_v_o, pc_w_v_o}, 0);
    sync();

    send(mk(my_id, 3'd1, 32'h010, 32'h12345678));
    @(negedge clk);
    chk("instr_latency", imem_w_v_o, 1);
    chk("instr_run", run_o, 0);
    drain(20);

    send(mk(my_id ^ 6'd1, 3'd2, 32'd4, 32'h11111111));
    send(mk(my_id, 3'd2, 32'd3, 32'hDEADBEEF));
    drain(20);

    send(mk(my_id, 3'd3, 32'h020, 32'h5));
    @(negedge clk);
    chk("pc_strobe", pc_w_v_o, 1);
    chk("pc_run_before", run_o, 0);
    @(negedge clk);
    chk("pc_run_after", run_o, 1);
    sync();

    send(mk(my_id, 3'd4, 32'h0, 32'hA));
    @(negedge clk);
    chk("bar_running", bar_w_v_o, 1);
    chk("bar_run", run_o, 1);
    sync();
    send(mk(my_id, 3'd2, 32'd1, 32'd7));
    @(negedge clk);
    chk("reg_run_hold", run_o, 1);
    chk("reg_blocked", reg_w_v_o, 0);
    @(negedge clk);
    chk("stopping_run", run_o, 0);
    chk("stopping_nodisp", reg_w_v_o, 0);
    @(negedge clk);
    chk("halted_reg", reg_w_v_o, 1);
    chk("halted_run", run_o, 0);
    @(negedge clk);
    chk("stay_halted", run_o, 0);
    drain(20);

    rdy_cmd = 1'b0;
    instr_cyc.delete();
    for (int i = 0; i < 4; i++) send(mk(my_id, 3'd1, 32'(16 * i + 1), 32'(32'hC0DE0000 + i)));
    fork
      send(mk(my_id, 3'd1, 32'h3FF, 32'hC0DE0004));
      begin
        @(negedge clk); chk("full_ready0", net_ready_o, 0);
        @(negedge clk); chk("full_ready1", net_ready_o, 0);
        @(posedge clk); #1 rdy_cmd = 1'b1;
      end
    join
    drain(40);
    chk("instr_count", instr_cyc.size(), 5);
    if (instr_cyc.size() == 5) chk("instr_consecutive", instr_cyc[4] - instr_cyc[0], 4);

    for (int i = 0; i < 260; i++) send(mk(my_id, 3'($urandom_range(5, 7)), $urandom, $urandom));
    drain(50);
    chk("err_saturate", err_cnt_o, (unk_cnt > 255) ? 255 : unk_cnt);

    rdy_cmd = 1'b0;
    send(mk(my_id, 3'd3, 32'h040, 32'h3));
    send(mk(my_id, 3'd1, 32'h050, 32'h1));
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_run", run_o, 0);
    chk("rst_mid_strobes", {imem_w_v_o, reg_w_v_o, bar_w_v_o, pc_w_v_o}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    unk_cnt = 0;
    rdy_cmd = 1'b1;
    @(negedge clk);
    chk("rst_mid_err", err_cnt_o, 0);
    chk("rst_mid_ready", net_ready_o, 1);
    repeat (6) @(negedge clk);
    chk("rst_mid_quiet_run", run_o, 0);
    sync();

    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [id_width_gp-1:0] id;
      id = ($urandom_range(0, 3) != 0) ? my_id : (my_id ^ 6'(1 << $urandom_range(0, 5)));
      send(mk(id, 3'($urandom_range(0, 7)), $urandom_range(0, 1023), $urandom));
      if ($urandom_range(0, 3) == 0) sync();
    end
    drain(3000);
    chk("rand_err", err_cnt_o, (unk_cnt > 255) ? 255 : unk_cnt);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
